qeu_stream: RTL

- Downstream consumer of the double-buffered query memory.
- Waits for qeu_load_done, then reads QEU_LEN queries of (SQG_SIZE+2) 16-bit words each through qeu_read_addr.
- Presents the words as a valid/ready stream to the sDTW engine, with a per-query last flag and header marking.
- After the final word is accepted, pulses qeu_next so the memory swaps read/write buffers.

---
 rtl/sdtw_pkg.sv | 25 ++
 rtl/qeu_skid_fifo.sv | 53 +++++
 rtl/qeu_stream.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/sdtw_pkg.sv
// Shared types for the sDTW query path: stream FSM encoding and the per-word
// tag that travels alongside each query-memory read.
package sdtw_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_NEXT   = 2'd3
    } state_t;

    // Each query starts with two header words before the squiggle samples.
    localparam int HDR_WORDS = 2;

    // Query index field is sized for the largest supported QEU_LEN; the stream
    // block uses only the low $clog2(QEU_LEN) bits.
    localparam int QID_W_MAX = 8;

    typedef struct packed {
        logic                 hdr;
        logic                 last;
        logic [QID_W_MAX-1:0] qid;
    } tag_t;

endpackage

// File: rtl/qeu_skid_fifo.sv
// Two-entry first-word-fall-through buffer. The head entry is visible on o_data
// and stays put until popped, which keeps stalled output words stable.
module qeu_skid_fifo #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [DW-1:0] i_data,
    input  logic          i_pop,
    output logic [DW-1:0] o_data,
    output logic          o_valid,
    output logic [1:0]    o_count
);

    logic [DW-1:0] r_mem [2];
    logic          r_wr_ptr;
    logic          r_rd_ptr;
    logic [1:0]    r_count;
    logic          w_push;
    logic          w_pop;

    assign w_pop  = i_pop && (r_count != 2'd0);
    assign w_push = i_push && ((r_count != 2'd2) || w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_valid = (r_count != 2'd0);
    assign o_count = r_count;

endmodule

// File: rtl/qeu_stream.sv
// Reads one full query buffer from the synchronous query memory and streams it
// to the sDTW engine with header/last/query-id marking, then requests a swap.
//
// Stream handshake: a word moves when out_valid && out_ready on a rising clk
// edge; once out_valid is high, out_valid and the word stay unchanged until
// that transfer happens.
module qeu_stream
    import sdtw_pkg::*;
#(
    parameter int WIDTH            = 16,
    parameter int SQG_SIZE         = 200,
    parameter int QEU_LEN          = 8,
    parameter int QEUMEM_PTR_WIDTH = 11,
    parameter int QEU_SIZE         = (SQG_SIZE + 2) * QEU_LEN,
    localparam int QID_W           = $clog2(QEU_LEN),
    localparam int WIDX_W          = $clog2(SQG_SIZE + 2)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic                        qeu_load_done,
    output logic [QEUMEM_PTR_WIDTH-1:0] qeu_read_addr,
    input  logic [WIDTH-1:0]            dataout_qeu,
    output logic                        qeu_next,
    output logic [WIDTH-1:0]            out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_hdr,
    output logic                        out_last,
    output logic [QID_W-1:0]            out_qid,
    output logic                        busy,
    output logic [15:0]                 buf_count,
    output state_t                      dbg_state
);

    localparam int TAG_W = $bits(tag_t);
    localparam int FW    = WIDTH + TAG_W;
    localparam int PW    = QEUMEM_PTR_WIDTH;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [PW-1:0]         r_addr;
    logic [PW-1:0]         r_addr_last;
    logic [WIDX_W-1:0]     r_widx;
    logic [QID_W-1:0]      r_qid;
    logic                  r_inflight;
    tag_t                  r_tag_inflight;
    logic [15:0]           r_buf_count;

    tag_t                  w_tag_issue;
    tag_t                  w_tag_out;
    logic [FW-1:0]         w_fifo_dout;
    logic                  w_fifo_valid;
    logic [1:0]            w_fifo_count;
    logic                  w_pop;
    logic [1:0]            w_occ_after;
    logic                  w_issue;
    logic                  w_start;
    logic                  w_last_addr;
    logic                  w_widx_wrap;
    logic                  w_unused_qid;

    // Occupancy the buffer will have after this cycle's return and pop; a new
    // read is only issued when its data is guaranteed a free slot.
    assign w_pop       = w_fifo_valid && out_ready;
    assign w_occ_after = w_fifo_count + {1'b0, r_inflight} - {1'b0, w_pop};
    assign w_issue     = (r_state == ST_STREAM) && (w_occ_after < 2'd2);
    assign w_start     = (r_state == ST_IDLE) && qeu_load_done && enable;
    assign w_last_addr = (r_addr == PW'(QEU_SIZE - 1));
    assign w_widx_wrap = (r_widx == WIDX_W'(SQG_SIZE + 1));

    always_comb begin
        w_tag_issue      = '0;
        w_tag_issue.hdr  = (r_widx < WIDX_W'(HDR_WORDS));
        w_tag_issue.last = w_widx_wrap;
        w_tag_issue.qid  = QID_W_MAX'(r_qid);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_start) w_state_nxt = ST_STREAM;
            ST_STREAM: if (w_issue && w_last_addr) w_state_nxt = ST_DRAIN;
            ST_DRAIN:  if (w_occ_after == 2'd0) w_state_nxt = ST_NEXT;
            ST_NEXT:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr         <= '0;
            r_addr_last    <= '0;
            r_widx         <= '0;
            r_qid          <= '0;
            r_inflight     <= 1'b0;
            r_tag_inflight <= '0;
            r_buf_count    <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_start) begin
                r_addr <= '0;
                r_widx <= '0;
                r_qid  <= '0;
            end else if (w_issue) begin
                r_addr         <= r_addr + PW'(1);
                r_addr_last    <= r_addr;
                r_tag_inflight <= w_tag_issue;
                if (w_widx_wrap) begin
                    r_widx <= '0;
                    r_qid  <= r_qid + QID_W'(1);
                end else begin
                    r_widx <= r_widx + WIDX_W'(1);
                end
            end
            if (r_state == ST_NEXT) begin
                r_buf_count <= r_buf_count + 16'd1;
            end
        end
    end

    qeu_skid_fifo #(
        .DW(FW)
    ) u_skid (
        .clk    (clk),
        .rst    (rst),
        .i_push (r_inflight),
        .i_data ({dataout_qeu, r_tag_inflight}),
        .i_pop  (w_pop),
        .o_data (w_fifo_dout),
        .o_valid(w_fifo_valid),
        .o_count(w_fifo_count)
    );

    assign w_tag_out     = w_fifo_dout[TAG_W-1:0];
    assign w_unused_qid  = ^w_tag_out.qid;

    // Address is live while issuing and otherwise holds the last issued value.
    assign qeu_read_addr = w_issue ? r_addr : r_addr_last;
    assign qeu_next      = (r_state == ST_NEXT);
    assign busy          = (r_state != ST_IDLE);
    assign buf_count     = r_buf_count;
    assign out_valid     = w_fifo_valid;
    assign out_data      = w_fifo_dout[FW-1 -: WIDTH];
    assign out_hdr       = w_tag_out.hdr;
    assign out_last      = w_tag_out.last;
    assign out_qid       = w_tag_out.qid[QID_W-1:0];
    assign dbg_state     = r_state;

endmodule
